// File: rtl/riscv_pkg.sv
// Shared LSU definitions: FSM states, RV32I funct3 load/store codes and
// small decode helpers used by the LSU datapath.
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // Only meaningful for legal codes; f3[1:0] encodes the access size.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] offset);
        return ((f3[1:0] == 2'b01) && offset[0]) ||
               ((f3[1:0] == 2'b10) && (offset != 2'b00));
    endfunction

    function automatic logic [3:0] be_mask(input logic [2:0] f3, input logic [1:0] offset);
        case (f3[1:0])
            2'b00:   return 4'b0001 << offset;
            2'b01:   return 4'b0011 << offset;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3[1:0])
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half from a read word and sign- or zero-extends it.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    // Extend the low byte/half of the shifted word according to the load type.
    always_comb begin
        o_data = '0;
        case (i_funct3)
            F3_LB:   o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_LH:   o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_LW:   o_data = i_rdata;
            F3_LBU:  o_data = {24'd0, w_shifted[7:0]};
            F3_LHU:  o_data = {16'd0, w_shifted[15:0]};
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory op from EX, runs a single bus
// transaction (or faults locally on misaligned/illegal ops) and returns a
// one-cycle completion pulse.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | ready for a new op
//   REQ     | bus request asserted, waiting for grant
//   WAIT    | load granted, waiting for read data
//   RESP    | one-cycle completion (resp_valid)
module lsu
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  busy
);

    lsu_state_t            r_state;
    lsu_state_t            w_next;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [2:0]            r_funct3;
    logic                  r_is_store;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_resp_data;
    logic                  w_accept;
    logic                  w_bad;
    logic [DATA_WIDTH-1:0] w_ext_data;

    assign w_accept = req_valid && (r_state == ST_IDLE);
    assign w_bad    = !f3_legal(req_is_store, req_funct3) ||
                      f3_misaligned(req_funct3, req_addr[1:0]);

    load_extend u_load_extend (
        .i_rdata  (mem_rdata),
        .i_offset (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_data   (w_ext_data)
    );

    // State register; reset abandons any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state and state-decoded outputs; bus/response outputs depend only
    // on registered state and latched op fields.
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        busy       = 1'b1;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = 4'b0000;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_data  = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (w_accept)
                    w_next = w_bad ? ST_RESP : ST_REQ;
            end
            ST_REQ: begin
                mem_req  = 1'b1;
                mem_we   = r_is_store;
                mem_addr = {r_addr[DATA_WIDTH-1:2], 2'b00};
                mem_be   = be_mask(r_funct3, r_addr[1:0]);
                if (r_is_store)
                    mem_wdata = store_lanes(r_funct3, r_wdata);
                if (mem_gnt)
                    w_next = r_is_store ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rvalid)
                    w_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                resp_data  = r_resp_data;
                w_next     = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Latch the op on handshake and capture extended load data in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_funct3    <= 3'b000;
            r_is_store  <= 1'b0;
            r_err       <= 1'b0;
            r_resp_data <= '0;
        end else if (w_accept) begin
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_funct3    <= req_funct3;
            r_is_store  <= req_is_store;
            r_err       <= w_bad;
            r_resp_data <= '0;
        end else if ((r_state == ST_WAIT) && mem_rvalid) begin
            r_resp_data <= w_ext_data;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Randomised bench for the LSU against a behavioural model of the
// load/store rules.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_data;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    lsu #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_data    (resp_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---- reference model ----
    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit m_err(input bit st, input logic [2:0] f3, input logic [31:0] addr);
        bit legal;
        int n = nbytes(f3);
        int off = int'(addr % 4);
        if (st) legal = (f3 <= 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        return !legal || (n == 2 && (off % 2) != 0) || (n == 4 && off != 0);
    endfunction

    function automatic logic [31:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
        int n = nbytes(f3);
        int v = ((1 << n) - 1) << (addr % 4);
        return 32'(v & 15);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
        int n = nbytes(f3);
        if (n == 1) return (w & 32'hFF) * 32'h01010101;
        if (n == 2) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        int n = nbytes(f3);
        logic [31:0] v = rdata >> (8 * (addr % 4));
        bit sgn = (f3 < 3'd4);
        if (n == 1) begin
            v = v & 32'hFF;
            if (sgn && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (n == 2) begin
            v = v & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    // One complete op starting from IDLE at a negedge; gdly/rdly are the
    // number of extra cycles before grant / read data.
    task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int gdly, input int rdly);
        bit err = m_err(st, f3, addr);
        chk("idle_ready", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wdata;
        @(negedge clk);
        req_valid    = 1'b0;
        req_is_store = 1'($urandom);
        req_funct3   = 3'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        if (err) begin
            chk("err_mem_req", 32'(mem_req), 32'd0);
        end else begin
            for (int i = 0; i <= gdly; i++) begin
                chk("req_mem_req", 32'(mem_req), 32'd1);
                chk("req_addr", mem_addr, addr & 32'hFFFFFFFC);
                chk("req_be", 32'(mem_be), m_be(f3, addr));
                chk("req_we", 32'(mem_we), 32'(st));
                if (st) chk("req_wdata", mem_wdata, m_wdata(f3, wdata));
                chk("req_busy", 32'(busy), 32'd1);
                chk("req_ready_low", 32'(req_ready), 32'd0);
                chk("req_no_resp", 32'(resp_valid), 32'd0);
                mem_gnt    = (i == gdly);
                mem_rvalid = (i < gdly) ? 1'($urandom) : 1'b0;
                mem_rdata  = $urandom;
                @(negedge clk);
            end
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (!st) begin
                for (int i = 0; i <= rdly; i++) begin
                    chk("wait_mem_req", 32'(mem_req), 32'd0);
                    chk("wait_no_resp", 32'(resp_valid), 32'd0);
                    chk("wait_busy", 32'(busy), 32'd1);
                    mem_rvalid = (i == rdly);
                    mem_rdata  = (i == rdly) ? rdata : $urandom;
                    @(negedge clk);
                end
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
        end
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_err", 32'(resp_err), 32'(err));
        chk("resp_data", resp_data, (err || st) ? 32'd0 : m_load(f3, addr, rdata));
        @(negedge clk);
        chk("post_resp_valid", 32'(resp_valid), 32'd0);
        chk("post_ready", 32'(req_ready), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_be"}, 32'(mem_be), 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_rv"}, 32'(resp_valid), 32'd0);
        chk({tag, "_rerr"}, 32'(resp_err), 32'd0);
        chk({tag, "_rdata"}, resp_data, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = 3'b000;
        req_addr     = '0;
        req_wdata    = '0;
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("reset");

        // Directed cases
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
        run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 0);
        run_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 0);
        run_op(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0, 0);
        run_op(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0);
        run_op(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0);
        run_op(1'b1, 3'b100, 32'h100, 32'h5, 32'h0, 0, 0);
        run_op(1'b1, 3'b010, 32'h102, 32'h5, 32'h0, 0, 0);
        run_op(1'b0, 3'b001, 32'h105, 32'h0, 32'h0, 0, 0);
        run_op(1'b0, 3'b101, 32'h106, 32'h0, 32'h8001F234, 5, 2);
        run_op(1'b1, 3'b000, 32'h3FD, 32'hCAFE00A5, 32'h0, 5, 0);

        // Reset while waiting for read data, then a late rvalid
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h300; req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rst_in_wait_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_quiet("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_quiet("rst_late_rvalid");
            @(negedge clk);
        end
        run_op(1'b0, 3'b010, 32'h304, 32'h0, 32'hA5A5_5A5A, 0, 0);

        // Randomised ops, mostly legal
        for (int k = 0; k < 200; k++) begin
            st = 1'($urandom);
            if ($urandom_range(0, 7) == 0)
                f3 = 3'($urandom);
            else if (st)
                f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (nbytes(f3) == 2) a[0] = 1'b0;
                if (nbytes(f3) == 4) a[1:0] = 2'b00;
            end
            run_op(st, f3, a, $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
